// File: rtl/mux_pkg.sv
// Shared types and limits for the round-robin stream multiplexer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mux_pkg;

    // Arbitration policy, driven at run time from the prio_mode pin.
    typedef enum logic {
        MODE_RR    = 1'b0,
        MODE_FIXED = 1'b1
    } arb_mode_e;

    // Supported channel-count range for stream_mux_rr.
    localparam int MAX_CH = 16;
    localparam int MIN_CH = 2;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational arbiter: round-robin (search from ptr+1 upward, wrapping) or fixed priority (lowest index).
// Latency: 0 cycles, purely combinational.
// Backpressure: none here; the caller qualifies the grant with its own load condition.
//
// Ports:
//   req     - per-channel request vector
//   ptr     - index of the last granted channel (round-robin search starts one above it)
//   mode    - MODE_RR or MODE_FIXED
//   gnt     - one-hot grant (all zero when nothing requests)
//   gnt_idx - binary index of the granted channel
//   gnt_any - a grant was issued
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int SEL_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    input  arb_mode_e        mode,
    output logic [N_CH-1:0]  gnt,
    output logic [SEL_W-1:0] gnt_idx,
    output logic             gnt_any
);

    int               cand;
    logic [SEL_W-1:0] cand_idx;

    // Candidates are visited from lowest priority to highest so the last hit
    // wins. The modulo keeps the wrap at N_CH-1 -> 0 even when N_CH is not a
    // power of two, so out-of-range indices are never produced.
    always_comb begin
        gnt      = '0;
        gnt_idx  = '0;
        gnt_any  = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int k = N_CH; k >= 1; k--) begin
            if (mode == MODE_FIXED) begin
                cand = k - 1;
            end else begin
                cand = (int'(ptr) + k) % N_CH;
            end
            cand_idx = SEL_W'(cand);
            if (req[cand_idx]) begin
                gnt_any = 1'b1;
                gnt_idx = cand_idx;
            end
        end
        if (gnt_any) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// N_CH:1 valid/ready stream mux with run-time selectable round-robin or fixed-priority arbitration.
// Latency: 1 cycle from input acceptance to out_valid; sustains 1 beat/cycle.
// Backpressure: in_ready is combinational from out_ready; all in_ready drop while a held beat stalls.
//
// Ports:
//   clk, rst   - clock and synchronous active-high reset
//   prio_mode  - 0 = round-robin, 1 = fixed priority (lowest index wins)
//   in_valid / in_ready / in_data - per-channel handshakes, payload i at [i*DATA_W +: DATA_W]
//   out_valid / out_ready / out_data / out_sel - registered output beat and its source channel
module stream_mux_rr
    import mux_pkg::*;
#(
    parameter int N_CH   = 4,
    parameter int DATA_W = 8,
    parameter int SEL_W  = $clog2(N_CH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     prio_mode,
    input  logic [N_CH-1:0]          in_valid,
    output logic [N_CH-1:0]          in_ready,
    input  logic [N_CH*DATA_W-1:0]   in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [SEL_W-1:0]         out_sel
);

    generate
        if (N_CH < MIN_CH || N_CH > MAX_CH) begin : g_bad_n_ch
            $error("stream_mux_rr: N_CH out of supported range");
        end
        if (DATA_W < 1) begin : g_bad_data_w
            $error("stream_mux_rr: DATA_W must be at least 1");
        end
    endgenerate

    logic [SEL_W-1:0]  ptr;
    logic [N_CH-1:0]   gnt;
    logic [SEL_W-1:0]  gnt_idx;
    logic              gnt_any;
    logic              load;
    logic              in_xfer;
    logic [DATA_W-1:0] sel_data;

    rr_arbiter #(
        .N_CH  (N_CH),
        .SEL_W (SEL_W)
    ) u_arb (
        .req     (in_valid),
        .ptr     (ptr),
        .mode    (arb_mode_e'(prio_mode)),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    // The output register can take a new beat when empty or when its current
    // beat leaves this cycle; this is the intended out_ready -> in_ready path.
    assign load     = ~out_valid | out_ready;
    assign in_ready = (rst || !load) ? '0 : gnt;
    assign in_xfer  = gnt_any & load & ~rst;

    // One-hot AND-OR select so only the granted payload can ever be captured.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (gnt[i]) begin
                sel_data = in_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            ptr       <= SEL_W'(N_CH - 1);
        end else if (in_xfer) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_sel   <= gnt_idx;
            // Pointer tracks grants in both modes so round-robin resumes fairly.
            ptr       <= gnt_idx;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stream_mux_rr.sv
module tb_stream_mux_rr;

    localparam int N  = 4;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          prio_mode;
    logic [N-1:0]  in_valid;
    logic [N-1:0]  in_ready;
    logic [N*DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [1:0]    out_sel;

    stream_mux_rr #(.N_CH(N), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .prio_mode (prio_mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sel   (out_sel)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] d;
        logic [1:0]    s;
    } beat_t;

    beat_t      exp_q[$];
    logic [1:0] seen_sel[$];

    // Reference state: whether the output register holds a beat and the last grant.
    logic m_valid = 1'b0;
    int   m_ptr   = N - 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Winner by the arbitration rules: first requester in the rotation that
    // starts just above the last grant, or the lowest requester in fixed mode.
    function automatic int pick(input logic [N-1:0] v, input int ptr, input logic fixed);
        int order[$];
        if (fixed) begin
            for (int i = 0; i < N; i++) order.push_back(i);
        end else begin
            for (int k = 1; k <= N; k++) order.push_back((ptr + k) % N);
        end
        foreach (order[j]) begin
            if (((v >> order[j]) & 4'd1) != 4'd0) return order[j];
        end
        return -1;
    endfunction

    // Drive one cycle at the falling edge, check in_ready and out_valid, then
    // advance the model to what the next rising edge should produce.
    task automatic cycle(input logic r, input logic [N-1:0] v, input logic [N*DW-1:0] d,
                         input logic ordy, input logic mode);
        int         g;
        logic       ld;
        logic [N-1:0] exp_rdy;
        beat_t      b;
        @(negedge clk);
        rst = r; in_valid = v; in_data = d; out_ready = ordy; prio_mode = mode;
        #1;
        if (!r) chk("out_valid", out_valid, m_valid);
        ld = !m_valid || ordy;
        g = pick(v, m_ptr, mode);
        exp_rdy = '0;
        if (!r && ld && g >= 0) exp_rdy = 4'b0001 << g;
        chk("in_ready", in_ready, exp_rdy);
        if (r) begin
            exp_q.delete();
            m_valid = 1'b0;
            m_ptr = N - 1;
        end else if (ld && g >= 0) begin
            b.d = 8'(d >> (DW * g));
            b.s = 2'(g);
            exp_q.push_back(b);
            m_valid = 1'b1;
            m_ptr = g;
        end else if (ordy) begin
            m_valid = 1'b0;
        end
    endtask

    // Monitor: while a beat is presented it must match the oldest expected
    // beat (which also covers stability during stalls); pop on handshake.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst && out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_out_valid", 32'(out_valid), 32'd0);
                end else begin
                    chk("out_data", out_data, exp_q[0].d);
                    chk("out_sel", out_sel, exp_q[0].s);
                    if (out_ready) begin
                        seen_sel.push_back(out_sel);
                        exp_q.delete(0);
                    end
                end
            end
        end
    end

    localparam logic [N*DW-1:0] DATA_A = 32'hA3A2_A1A0;

    initial begin
        logic       mode;
        logic       r;
        logic       ordy;
        rst = 1'b1; prio_mode = 1'b0; in_valid = '0; in_data = '0; out_ready = 1'b0;

        // Reset with every channel requesting: nothing may be accepted.
        cycle(1'b1, 4'hF, DATA_A, 1'b1, 1'b0);
        cycle(1'b1, 4'hF, DATA_A, 1'b1, 1'b0);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_data", 32'(out_data), 32'd0);
        chk("reset_out_sel", 32'(out_sel), 32'd0);

        // Round-robin fairness, one beat per cycle starting at channel 0.
        seen_sel.delete();
        repeat (6) cycle(1'b0, 4'hF, DATA_A, 1'b1, 1'b0);
        cycle(1'b0, 4'h0, DATA_A, 1'b1, 1'b0);
        #2;
        chk("fair_count", seen_sel.size(), 6);
        for (int i = 0; i < 6 && i < seen_sel.size(); i++) begin
            chk("fair_order", 32'(seen_sel[i]), i % N);
        end

        // Fixed priority, then drop the winning channel.
        repeat (4) cycle(1'b0, 4'b0110, DATA_A, 1'b1, 1'b1);
        repeat (2) cycle(1'b0, 4'b0100, DATA_A, 1'b1, 1'b1);

        // Backpressure: load, stall 5 cycles, then transfer-plus-reload.
        cycle(1'b0, 4'hF, DATA_A, 1'b1, 1'b0);
        repeat (5) cycle(1'b0, 4'hF, DATA_A, 1'b0, 1'b0);
        repeat (2) cycle(1'b0, 4'hF, DATA_A, 1'b1, 1'b0);

        // Sparse requests and wrap-around.
        cycle(1'b0, 4'b1000, DATA_A, 1'b1, 1'b0);
        cycle(1'b0, 4'b0100, DATA_A, 1'b1, 1'b0);
        repeat (2) cycle(1'b0, 4'b1001, DATA_A, 1'b1, 1'b0);

        // Reset while a beat is stalled.
        cycle(1'b0, 4'hF, DATA_A, 1'b1, 1'b0);
        cycle(1'b0, 4'hF, DATA_A, 1'b0, 1'b0);
        cycle(1'b1, 4'hF, DATA_A, 1'b0, 1'b0);
        repeat (2) cycle(1'b0, 4'b0110, DATA_A, 1'b1, 1'b0);

        // Randomised traffic with occasional resets and mode flips.
        mode = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 19) == 0) mode = ~mode;
            r    = ($urandom_range(0, 59) == 0);
            ordy = ($urandom_range(0, 3) != 0);
            cycle(r, 4'($urandom), 32'($urandom), ordy, mode);
        end

        // Drain and confirm every predicted beat came out.
        repeat (3) cycle(1'b0, 4'h0, DATA_A, 1'b1, 1'b0);
        #2;
        chk("queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
